nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 2: operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: operands present.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have port in_a, input, W: operand A.
REQ-007 SHALL have port in_b, input, W: operand B.
REQ-008 SHALL have port in_cin, input, 1: carry-in.
REQ-009 SHALL have port in_acc, input, 1: 1 means use the last result in place of in_a.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port out_sum, output, W: result.
REQ-013 SHALL have port out_cout, output, 1: carry-out of the MSB nibble.

Function
REQ-014 SHALL implement FSM states IDLE, ADD and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL, on in_valid&in_ready, register A (in_acc ? result register : in_a), in_b and in_cin into operand registers, clear nibble index, and go to ADD.
REQ-017 SHALL, in each ADD cycle, add nibble[idx] of A, nibble[idx] of B and carry register in one 4-bit adder instance, write the 4-bit sum into result nibble idx, store the carry, and increment idx.
REQ-018 SHALL seed the carry register with in_cin at acceptance.
REQ-019 SHALL, in the ADD cycle with idx=NIBBLES-1, go to DONE and latch the final carry into out_cout.
REQ-020 SHALL give latency: operands accepted on edge E, out_valid high from edge E+NIBBLES.
REQ-021 SHALL, in DONE with out_ready=1, complete the transfer and return to IDLE on that edge; the next acceptance is possible one cycle later.
REQ-022 SHALL hold out_sum and out_cout stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 SHALL ignore in_valid and all operand inputs outside IDLE.
REQ-024 SHALL retain the result register after handshake for in_acc use; its value changes only at ADD completion or reset.
REQ-025 SHALL discard arithmetic overflow (wrap modulo 2^W), with out_cout=1 marking it (REQ-033 applies when compiled in).

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, enter IDLE regardless of current state, abandoning any in-flight addition.
REQ-027 SHALL reset out_valid=0, in_ready=1 (combinational from IDLE), out_sum=0, out_cout=0, result register=0, carry=0, idx=0.
REQ-028 SHALL produce no result for an addition interrupted by reset.
REQ-029 SHALL accept input on the first edge after rst_n returns to 1.

Configuration
REQ-030 SHALL support macro NIBBLE_SERIAL_ADDER_SAT_EN.
REQ-031 SHALL, without the macro, wrap the result (REQ-025).
REQ-032 SHALL, with the macro, force out_sum to all-ones when the final carry is 1, with out_cout still 1.
REQ-033 SHALL, with the macro, also store the saturated value into the result register used for in_acc.

Structure
REQ-034 SHALL place the FSM state enum and the constant NIBBLE_W=4 in shared package nibble_serial_adder_pkg.
REQ-035 SHALL instantiate exactly one sub-module, nsa_add4, a combinational 4-bit adder with a, b, cin, s and cout, built from full-adder cells.

Verification
REQ-036 SHALL cover: NIBBLES=2, accept 0x3C+0x05, cin=0, out_ready=1 -> out_sum=0x41, out_cout=0, out_valid first high 2 edges after accept.
REQ-037 SHALL cover: 0xFF+0x01, cin=0 -> wrap: 0x00, cout=1; with NIBBLE_SERIAL_ADDER_SAT_EN: 0xFF, cout=1.
REQ-038 SHALL cover: 0x0F+0x00, cin=1 -> 0x10, cout=0, proving the inter-nibble carry.
REQ-039 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> out_sum constant, in_ready=0, in_valid pulses ignored, one result on release.
REQ-040 SHALL cover: accumulate 0x20 (in_acc=0), then 0x30 with in_acc=1, in_b=0x30 -> second result 0x50.
REQ-041 SHALL cover: rst_n=0 during the first ADD cycle -> next edge IDLE, out_valid never asserts for that operation, result register=0.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nsa_add4.sv
// Combinational 4-bit ripple adder assembled from full-adder cells.
module nsa_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit adder reused over NIBBLES cycles, with a
// valid/ready handshake on both sides and an accumulate option (in_acc).
// Build option: define NIBBLE_SERIAL_ADDER_SAT_EN to saturate the sum to
// all-ones on final carry instead of wrapping.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ADD   | adding nibble idx, one nibble per cycle
// DONE  | result presented, out_valid=1, held until out_ready
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 2,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                             state;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   op_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   op_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   work;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   fin;
  logic [W-1:0]                       fin_w;
  logic [W-1:0]                       res;
  logic                               carry;
  logic                               cout_q;
  logic [IDX_W-1:0]                   idx;
  logic [NIBBLE_W-1:0]                add_s;
  logic                               add_c;

  nsa_add4 u_add4 (
    .a   (op_a[idx]),
    .b   (op_b[idx]),
    .cin (carry),
    .s   (add_s),
    .cout(add_c)
  );

  // Result as it will look once the current (last) nibble lands, with optional saturation.
  always_comb begin
    fin      = work;
    fin[idx] = add_s;
    fin_w    = fin;
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
    if (add_c) fin_w = '1;
`endif
  end

  // Handshake sequencing, nibble stepping and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_acc ? res : in_a;
            op_b  <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          work[idx] <= add_s;
          carry     <= add_c;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // res doubles as the accumulate source, so it only moves here.
            res    <= fin_w;
            cout_q <= add_c;
            idx    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = res;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: driver pushes model results,
// monitor pops and compares on each output handshake.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 2;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int checks = 0;
  int errors = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] model_acc = '0;
  bit           rand_bp = 1'b0;
  bit           hold = 1'b0;
  logic [W:0]   held = '0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_acc   (in_acc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, carry = bit W, optional saturation.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
    if (full[W]) full[W-1:0] = '1;
`endif
    return full;
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic acc, input bit expect_out);
    int n = 0;
    logic [W:0] r;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
      return;
    end
    if (expect_out) begin
      r = model(acc ? model_acc : a, b, cin);
      model_acc = r[W-1:0];
      exp_q.push_back(r);
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_acc = acc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_cin = 1'($urandom);
    in_acc = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // Random backpressure when enabled.
  initial forever begin
    @(negedge clk);
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares on each output handshake, checks stability under stall.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      hold = 1'b0;
      continue;
    end
    if (hold) begin
      check("stall_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
      check("stall_stable", {out_cout, out_sum}, held);
      check("stall_in_ready", {{W{1'b0}}, in_ready}, '0);
    end
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h, required no output", {out_cout, out_sum});
        end else begin
          check("result", {out_cout, out_sum}, exp_q.pop_front());
        end
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = {out_cout, out_sum};
      end
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    check("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    check("rst_out", {out_cout, out_sum}, '0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 0x3C+0x05 on the first edge after reset release, with latency check.
    send(8'h3C, 8'h05, 1'b0, 1'b0, 1'b1);
    check("accept_first_edge", {{W{1'b0}}, in_ready}, '0);
    @(negedge clk);
    check("lat_e1", {{W{1'b0}}, out_valid}, '0);
    @(negedge clk);
    check("lat_e2", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
    drain();

    send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    drain();
    send(8'h0F, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();
    send(8'h20, 8'h00, 1'b0, 1'b0, 1'b1);
    send(8'h77, 8'h30, 1'b0, 1'b1, 1'b1);
    drain();

    // Stall for 5 cycles with ignored input pulses.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_acc = 1'($urandom);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during the first ADD cycle: no result, result register cleared.
    send(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    check("midrst_out_valid", {{W{1'b0}}, out_valid}, '0);
    check("midrst_out", {out_cout, out_sum}, '0);
    rst_n = 1'b1;
    model_acc = '0;
    send(8'h99, 8'h07, 1'b0, 1'b1, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1);
    end
    @(negedge clk);
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
